cache_addr_sequencer: RTL and testbench
=======================================

# cache_addr_sequencer

Parametrised address front end for the cache controller's refill path. Splits a request address into tag/index/block-offset/word-offset fields, geometry set by parameters, and holds them for the duration of the request. Generates one word-aligned address beat per word of the containing block, in linear or critical-word-first (wrapping) order. Sits between the miss detector and the memory-side refill interface, with valid/ready handshakes on both sides.

## Interface
- ADDR_W, 32, request/beat address width
- INDEX_W, 7, set index width (128 sets)
- WORDS_PER_BLOCK, 16, words per block; power of 2, ≥2
- BYTES_PER_WORD, 4, bytes per word; power of 2, ≥2
- Derived: WORD_OFF_W=log2(BYTES_PER_WORD), BLK_OFF_W=log2(WORDS_PER_BLOCK), TAG_W=ADDR_W-INDEX_W-BLK_OFF_W-WORD_OFF_W (≥1, elaboration error otherwise)

- clk  in  1  single clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer idle, can accept
- req_addr  in  ADDR_W  byte address of the missing access
- req_wrap  in  1  1 = critical-word-first wrap order, 0 = linear from word 0
- abort  in  1  cancel current burst
- tag  out  TAG_W  addr[ADDR_W-1 -: TAG_W] of last accepted request
- index  out  INDEX_W  addr[WORD_OFF_W+BLK_OFF_W +: INDEX_W]
- block_offset  out  BLK_OFF_W  addr[WORD_OFF_W +: BLK_OFF_W]
- word_offset  out  WORD_OFF_W  addr[WORD_OFF_W-1:0]
- beat_valid  out  1  beat address valid
- beat_ready  in  1  memory side accepts beat
- beat_addr  out  ADDR_W  {tag, index, beat_word, WORD_OFF_W'b0}
- beat_word  out  BLK_OFF_W  word number within block of current beat
- beat_last  out  1  current beat is the final one of the block

## Operation
- States: IDLE, BURST. req_ready = (state==IDLE).
- IDLE: on req_valid & req_ready, register req_addr fields, req_wrap, start = block_offset; clear beat counter cnt; go BURST.
- BURST: beat_valid=1; beat_word = wrap ? (start+cnt) mod WORDS_PER_BLOCK : cnt; beat_last = (cnt==WORDS_PER_BLOCK-1).
- Beat handshake = beat_valid & beat_ready at rising edge; cnt increments by 1. On handshake with beat_last, go IDLE.
- Exactly WORDS_PER_BLOCK beats per request, each word of the block exactly once; wrap uses natural BLK_OFF_W-bit overflow.
- abort in BURST: go IDLE next edge, no further beats. abort together with a beat handshake: the beat counts as transferred, abort still wins (IDLE). abort in IDLE: ignored.
- Field outputs hold value from last accepted request until next acceptance (including after abort).
- Reset (rst_n low at an edge, any state, overrides all inputs): state IDLE, cnt/start/req_wrap 0, tag/index/block_offset/word_offset 0, beat_valid 0, beat_last 0, beat_addr 0, beat_word 0; req_ready reads 1 once state is IDLE. Requests presented during reset are not accepted.

## Timing
- Acceptance at edge N → fields valid and beat_valid high from cycle N+1 (1-cycle latency).
- Unstalled burst: WORDS_PER_BLOCK consecutive beats, cycles N+1 … N+WORDS_PER_BLOCK.
- beat_addr, beat_word and beat_last are stable while beat_valid & !beat_ready.
- Last handshake at edge M → req_ready high in cycle M+1; next acceptance earliest edge M+1 (one idle bubble; no back-to-back).
- All outputs registered or decoded from state/registers only; no combinational path from req_* or beat_ready to any output.

## Structure
- Package cache_addr_pkg: derived width functions/localparams (WORD_OFF_W, BLK_OFF_W, TAG_W), state enum {IDLE, BURST}.
- Sub-module addr_field_split: purely combinational, parametrised field decode (tag/index/block_offset/word_offset). Instantiated once on req_addr; its outputs are registered in the sequencer.

## Test plan
- Reset: rst_n low 2 cycles with req_valid=1 → all outputs 0, no acceptance; req_ready=1 after release, beat_valid=0.
- Decode (default params): req_addr=0x12345678 → tag=0x091A2, index=0x59, block_offset=0xE, word_offset=0 from the cycle after acceptance.
- Wrap burst, req_addr=0x12345678, req_wrap=1, beat_ready=1 → beat_addr 0x12345678, 0x1234567C, 0x12345640, …, 0x12345674 (beat_last); 16 beats; req_ready high one cycle after.
- Linear burst, same address, req_wrap=0 → beat_addr 0x12345640 … 0x1234567C, beat_last on 0x1234567C only.
- Backpressure: beat_ready low 3 cycles during beat 2 → beat_addr/beat_word held, still exactly 16 distinct beats total.
- Abort after beat 5 handshake (abort coincident with beat 6 handshake) → beat_valid 0 next cycle, req_ready 1, fields unchanged; new request 0x0000_0040 accepted and produces 16 fresh beats starting 0x00000040.

Source files
------------

// File: rtl/cache_addr_pkg.sv
// Shared geometry helpers and state encoding for the refill address sequencer.
// Widths derive from block/word geometry so every user stays consistent.
package cache_addr_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } seq_state_t;

  function automatic int word_off_width(input int bytes_per_word);
    return $clog2(bytes_per_word);
  endfunction

  function automatic int blk_off_width(input int words_per_block);
    return $clog2(words_per_block);
  endfunction

  function automatic int tag_width(input int addr_w, input int index_w,
                                   input int words_per_block, input int bytes_per_word);
    return addr_w - index_w - blk_off_width(words_per_block) - word_off_width(bytes_per_word);
  endfunction

  localparam int DEF_ADDR_W          = 32;
  localparam int DEF_INDEX_W         = 7;
  localparam int DEF_WORDS_PER_BLOCK = 16;
  localparam int DEF_BYTES_PER_WORD  = 4;
  localparam int DEF_WORD_OFF_W      = word_off_width(DEF_BYTES_PER_WORD);
  localparam int DEF_BLK_OFF_W       = blk_off_width(DEF_WORDS_PER_BLOCK);
  localparam int DEF_TAG_W           = tag_width(DEF_ADDR_W, DEF_INDEX_W,
                                                 DEF_WORDS_PER_BLOCK, DEF_BYTES_PER_WORD);

endpackage

// File: rtl/addr_field_split.sv
// Combinational split of a byte address into tag / set index / block offset / word offset.
// Zero latency, no flow control; the caller registers whatever it needs.
module addr_field_split
  import cache_addr_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int INDEX_W    = DEF_INDEX_W,
  parameter int BLK_OFF_W  = DEF_BLK_OFF_W,
  parameter int WORD_OFF_W = DEF_WORD_OFF_W,
  localparam int TAG_W     = ADDR_W - INDEX_W - BLK_OFF_W - WORD_OFF_W
) (
  input  logic [ADDR_W-1:0]     addr,
  output logic [TAG_W-1:0]      tag,
  output logic [INDEX_W-1:0]    index,
  output logic [BLK_OFF_W-1:0]  block_offset,
  output logic [WORD_OFF_W-1:0] word_offset
);

  assign tag          = addr[ADDR_W-1 -: TAG_W];
  assign index        = addr[WORD_OFF_W+BLK_OFF_W +: INDEX_W];
  assign block_offset = addr[WORD_OFF_W +: BLK_OFF_W];
  assign word_offset  = addr[WORD_OFF_W-1:0];

endmodule

// File: rtl/cache_addr_sequencer.sv
// Refill address front end: latches request fields, then emits one word address per beat of the block
// (linear or critical-word-first); 1-cycle accept-to-first-beat, beats hold under beat_ready low, abort drops the burst.
module cache_addr_sequencer
  import cache_addr_pkg::*;
#(
  parameter int ADDR_W          = DEF_ADDR_W,
  parameter int INDEX_W         = DEF_INDEX_W,
  parameter int WORDS_PER_BLOCK = DEF_WORDS_PER_BLOCK,
  parameter int BYTES_PER_WORD  = DEF_BYTES_PER_WORD,
  localparam int WORD_OFF_W     = word_off_width(BYTES_PER_WORD),
  localparam int BLK_OFF_W      = blk_off_width(WORDS_PER_BLOCK),
  localparam int TAG_W          = tag_width(ADDR_W, INDEX_W, WORDS_PER_BLOCK, BYTES_PER_WORD)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic                  req_wrap,
  input  logic                  abort,
  output logic [TAG_W-1:0]      tag,
  output logic [INDEX_W-1:0]    index,
  output logic [BLK_OFF_W-1:0]  block_offset,
  output logic [WORD_OFF_W-1:0] word_offset,
  output logic                  beat_valid,
  input  logic                  beat_ready,
  output logic [ADDR_W-1:0]     beat_addr,
  output logic [BLK_OFF_W-1:0]  beat_word,
  output logic                  beat_last
);

  generate
    if (TAG_W < 1) begin : g_bad_tag_w
      $error("cache_addr_sequencer: geometry leaves no tag bits");
    end
    if (WORDS_PER_BLOCK < 2 || (WORDS_PER_BLOCK & (WORDS_PER_BLOCK - 1)) != 0) begin : g_bad_words
      $error("cache_addr_sequencer: WORDS_PER_BLOCK must be a power of 2, at least 2");
    end
    if (BYTES_PER_WORD < 2 || (BYTES_PER_WORD & (BYTES_PER_WORD - 1)) != 0) begin : g_bad_bytes
      $error("cache_addr_sequencer: BYTES_PER_WORD must be a power of 2, at least 2");
    end
  endgenerate

  localparam logic [BLK_OFF_W-1:0] LAST_CNT = BLK_OFF_W'(WORDS_PER_BLOCK - 1);

  seq_state_t state;
  logic [BLK_OFF_W-1:0]  cnt;
  logic [BLK_OFF_W-1:0]  start;
  logic                  wrap_q;

  logic [TAG_W-1:0]      split_tag;
  logic [INDEX_W-1:0]    split_index;
  logic [BLK_OFF_W-1:0]  split_block_offset;
  logic [WORD_OFF_W-1:0] split_word_offset;

  logic [BLK_OFF_W-1:0]  cnt_nxt;
  logic [BLK_OFF_W-1:0]  word_nxt;
  logic [BLK_OFF_W-1:0]  first_word;
  logic                  beat_hs;

  addr_field_split #(
    .ADDR_W     (ADDR_W),
    .INDEX_W    (INDEX_W),
    .BLK_OFF_W  (BLK_OFF_W),
    .WORD_OFF_W (WORD_OFF_W)
  ) u_split (
    .addr         (req_addr),
    .tag          (split_tag),
    .index        (split_index),
    .block_offset (split_block_offset),
    .word_offset  (split_word_offset)
  );

  assign req_ready  = (state == IDLE);
  assign beat_hs    = beat_valid & beat_ready;
  assign cnt_nxt    = cnt + 1'b1;
  // Wrap order relies on BLK_OFF_W-bit overflow to fold back to word 0.
  assign word_nxt   = wrap_q ? (start + cnt_nxt) : cnt_nxt;
  assign first_word = req_wrap ? split_block_offset : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      start        <= '0;
      wrap_q       <= 1'b0;
      tag          <= '0;
      index        <= '0;
      block_offset <= '0;
      word_offset  <= '0;
      beat_valid   <= 1'b0;
      beat_last    <= 1'b0;
      beat_addr    <= '0;
      beat_word    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            state        <= BURST;
            cnt          <= '0;
            start        <= split_block_offset;
            wrap_q       <= req_wrap;
            tag          <= split_tag;
            index        <= split_index;
            block_offset <= split_block_offset;
            word_offset  <= split_word_offset;
            beat_valid   <= 1'b1;
            beat_last    <= 1'b0;
            beat_word    <= first_word;
            beat_addr    <= {split_tag, split_index, first_word, {WORD_OFF_W{1'b0}}};
          end
        end
        BURST: begin
          if (beat_hs) begin
            cnt <= cnt_nxt;
          end
          // Abort beats a coincident handshake: that beat still counts, but the burst ends.
          if (abort || (beat_hs && beat_last)) begin
            state      <= IDLE;
            beat_valid <= 1'b0;
            beat_last  <= 1'b0;
          end else if (beat_hs) begin
            beat_word <= word_nxt;
            beat_addr <= {tag, index, word_nxt, {WORD_OFF_W{1'b0}}};
            beat_last <= (cnt_nxt == LAST_CNT);
          end
        end
        default: begin
          state      <= IDLE;
          beat_valid <= 1'b0;
          beat_last  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_addr_sequencer.sv
// Directed bench for cache_addr_sequencer at default geometry: a per-cycle vector table
// followed by hand-written burst sequences (wrap, linear, backpressure, abort).
module tb_cache_addr_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_wrap;
  logic        abort;
  logic [18:0] tag;
  logic [6:0]  index;
  logic [3:0]  block_offset;
  logic [1:0]  word_offset;
  logic        beat_valid;
  logic        beat_ready;
  logic [31:0] beat_addr;
  logic [3:0]  beat_word;
  logic        beat_last;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cache_addr_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_wrap     (req_wrap),
    .abort        (abort),
    .tag          (tag),
    .index        (index),
    .block_offset (block_offset),
    .word_offset  (word_offset),
    .beat_valid   (beat_valid),
    .beat_ready   (beat_ready),
    .beat_addr    (beat_addr),
    .beat_word    (beat_word),
    .beat_last    (beat_last)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst_n;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_wrap;
    logic        abort;
    logic        beat_ready;
    logic        e_ready;
    logic        e_bv;
    logic        chk_beat;
    logic [31:0] e_baddr;
    logic [3:0]  e_bword;
    logic        e_blast;
    logic [18:0] e_tag;
    logic [6:0]  e_idx;
    logic [3:0]  e_boff;
    logic [1:0]  e_woff;
  } vec_t;

  vec_t vecs[13];

  // One request's full burst, checking every beat against the expected order.
  task automatic run_burst(input string nm, input logic [31:0] addr, input logic wrap,
                           input int stall_k, input int stall_n, input int abort_k);
    logic [3:0]  start;
    logic [31:0] base;
    logic [3:0]  w;
    logic [15:0] seen;
    int k, stalled, cyc;
    bit done;
    start = addr[5:2];
    base  = {addr[31:6], 6'b0};
    seen = '0; k = 0; stalled = 0; cyc = 0; done = 0;

    chk({nm, "_ready_before"}, req_ready, 1);
    req_addr = addr; req_wrap = wrap; req_valid = 1'b1; beat_ready = 1'b0; abort = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk({nm, "_tag"}, tag, addr[31:13]);
    chk({nm, "_index"}, index, addr[12:6]);
    chk({nm, "_boff"}, block_offset, addr[5:2]);
    chk({nm, "_woff"}, word_offset, addr[1:0]);

    while (!done && cyc < 200) begin
      w = wrap ? 4'(start + 4'(k)) : 4'(k);
      chk({nm, "_bv"}, beat_valid, 1);
      chk({nm, "_baddr"}, beat_addr, base | (32'(w) << 2));
      chk({nm, "_bword"}, beat_word, w);
      chk({nm, "_blast"}, beat_last, (k == 15));
      chk({nm, "_ready_busy"}, req_ready, 0);
      beat_ready = !(k == stall_k && stalled < stall_n);
      if (!beat_ready) stalled++;
      abort = (k == abort_k) && beat_ready;
      @(posedge clk); #1;
      if (beat_ready) begin
        seen[w] = 1'b1;
        k++;
      end
      if (abort || k == 16) done = 1;
      cyc++;
    end
    beat_ready = 1'b0; abort = 1'b0;

    chk({nm, "_done_in_budget"}, done, 1);
    chk({nm, "_ready_after"}, req_ready, 1);
    chk({nm, "_bv_after"}, beat_valid, 0);
    chk({nm, "_tag_held"}, tag, addr[31:13]);
    chk({nm, "_boff_held"}, block_offset, addr[5:2]);
    if (abort_k < 16) chk({nm, "_beats_before_abort"}, k, abort_k + 1);
    else              chk({nm, "_all_words_once"}, {seen, 16'(k)}, {16'hFFFF, 16'd16});
    @(posedge clk); #1;
    chk({nm, "_idle_bv"}, beat_valid, 0);
  endtask

  initial begin
    // rst, vld, addr, wrap, abort, brdy | ready, bv, chk_beat, baddr, bword, blast, tag, idx, boff, woff
    vecs[0]  = '{0, 1, 32'h12345678, 1, 0, 0,  1, 0, 1, 32'h0,        4'h0, 0, 19'h0,     7'h00, 4'h0, 2'd0};
    vecs[1]  = '{0, 1, 32'h12345678, 1, 0, 0,  1, 0, 1, 32'h0,        4'h0, 0, 19'h0,     7'h00, 4'h0, 2'd0};
    vecs[2]  = '{1, 0, 32'h0,        0, 1, 0,  1, 0, 1, 32'h0,        4'h0, 0, 19'h0,     7'h00, 4'h0, 2'd0};
    vecs[3]  = '{1, 1, 32'h12345678, 1, 0, 0,  0, 1, 1, 32'h12345678, 4'hE, 0, 19'h091A2, 7'h59, 4'hE, 2'd0};
    vecs[4]  = '{1, 1, 32'h00000000, 0, 0, 0,  0, 1, 1, 32'h12345678, 4'hE, 0, 19'h091A2, 7'h59, 4'hE, 2'd0};
    vecs[5]  = '{1, 0, 32'h0,        0, 0, 1,  0, 1, 1, 32'h1234567C, 4'hF, 0, 19'h091A2, 7'h59, 4'hE, 2'd0};
    vecs[6]  = '{1, 0, 32'h0,        0, 0, 1,  0, 1, 1, 32'h12345640, 4'h0, 0, 19'h091A2, 7'h59, 4'hE, 2'd0};
    vecs[7]  = '{1, 0, 32'h0,        0, 1, 0,  1, 0, 0, 32'h0,        4'h0, 0, 19'h091A2, 7'h59, 4'hE, 2'd0};
    vecs[8]  = '{1, 0, 32'h0,        0, 0, 0,  1, 0, 0, 32'h0,        4'h0, 0, 19'h091A2, 7'h59, 4'hE, 2'd0};
    vecs[9]  = '{1, 1, 32'h12345678, 0, 0, 0,  0, 1, 1, 32'h12345640, 4'h0, 0, 19'h091A2, 7'h59, 4'hE, 2'd0};
    vecs[10] = '{0, 1, 32'h12345678, 1, 0, 1,  1, 0, 1, 32'h0,        4'h0, 0, 19'h0,     7'h00, 4'h0, 2'd0};
    vecs[11] = '{1, 1, 32'hFFFFE003, 1, 0, 0,  0, 1, 1, 32'hFFFFE000, 4'h0, 0, 19'h7FFFF, 7'h00, 4'h0, 2'd3};
    vecs[12] = '{1, 0, 32'h0,        0, 1, 1,  1, 0, 0, 32'h0,        4'h0, 0, 19'h7FFFF, 7'h00, 4'h0, 2'd3};

    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_wrap = 1'b0; abort = 1'b0; beat_ready = 1'b0;

    for (int i = 0; i < 13; i++) begin
      rst_n      = vecs[i].rst_n;
      req_valid  = vecs[i].req_valid;
      req_addr   = vecs[i].req_addr;
      req_wrap   = vecs[i].req_wrap;
      abort      = vecs[i].abort;
      beat_ready = vecs[i].beat_ready;
      @(posedge clk); #1;
      chk($sformatf("vec%0d_ready", i), req_ready, vecs[i].e_ready);
      chk($sformatf("vec%0d_bv", i), beat_valid, vecs[i].e_bv);
      if (vecs[i].chk_beat) begin
        chk($sformatf("vec%0d_baddr", i), beat_addr, vecs[i].e_baddr);
        chk($sformatf("vec%0d_bword", i), beat_word, vecs[i].e_bword);
        chk($sformatf("vec%0d_blast", i), beat_last, vecs[i].e_blast);
      end
      chk($sformatf("vec%0d_tag", i), tag, vecs[i].e_tag);
      chk($sformatf("vec%0d_index", i), index, vecs[i].e_idx);
      chk($sformatf("vec%0d_boff", i), block_offset, vecs[i].e_boff);
      chk($sformatf("vec%0d_woff", i), word_offset, vecs[i].e_woff);
    end

    rst_n = 1'b1; req_valid = 1'b0; abort = 1'b0; beat_ready = 1'b0;
    @(posedge clk); #1;

    run_burst("wrap",       32'h12345678, 1'b1, -1, 0, 99);
    run_burst("linear",     32'h12345678, 1'b0, -1, 0, 99);
    run_burst("stall",      32'h12345678, 1'b1,  2, 3, 99);
    run_burst("abort",      32'h12345678, 1'b0, -1, 0,  5);
    run_burst("post_abort", 32'h00000040, 1'b0, -1, 0, 99);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
